iq_accum_serializer: RTL

Parametrised successor to the fixed four-channel DDC accumulate/sequence stage. The block takes N_CH complex DDC outputs sharing one valid strobe and integrates I and Q per channel over a runtime-programmable frame length. It snapshots each completed frame and serialises it as one word per channel on a valid/ready stream. Unlike the previous stage, it supports backpressure, detects overruns, and tags each word with a channel index and last flag.

---
 rtl/iq_accum_serializer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/iq_accum_serializer.sv
// Per-channel I/Q frame integrator feeding a valid/ready word serializer; optional header word via IQ_ACCUM_HEADER_EN.
// First word 1 cycle after the final sample; words hold under backpressure, frames completing mid-burst are dropped and flagged.
module iq_accum_serializer #(
  parameter int N_CH  = 4,
  parameter int IN_W  = 32,
  parameter int LEN_W = 16,
  parameter int ACC_W = 48,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   dev_clk,
  input  logic                   dev_rst,
  input  logic [LEN_W-1:0]       length,
  input  logic                   resync,
  input  logic                   valid_in,
  input  logic [N_CH*2*IN_W-1:0] data_in,
  output logic [2*ACC_W-1:0]     out_data,
  output logic [CH_W-1:0]        out_ch,
  output logic                   out_last,
  output logic                   out_header,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state;

  logic [ACC_W-1:0] acc_i  [N_CH];
  logic [ACC_W-1:0] acc_q  [N_CH];
  logic [ACC_W-1:0] sum_i  [N_CH];
  logic [ACC_W-1:0] sum_q  [N_CH];
  logic [ACC_W-1:0] snap_i [N_CH];
  logic [ACC_W-1:0] snap_q [N_CH];

  logic [LEN_W-1:0] cnt, len_lat, len_eff;
  logic             frame_done, hs, final_hs, accept, drop;
  logic [CH_W-1:0]  nxt_ch;

`ifdef IQ_ACCUM_HEADER_EN
  logic [31:0] frame_cnt;
`else
  assign out_header = 1'b0;
`endif

  assign len_eff    = (length == '0) ? ONE : length;
  assign frame_done = valid_in && !resync && (cnt == len_lat - ONE);
  assign hs         = out_valid && out_ready;
  assign final_hs   = hs && out_last;
  // A frame closing on the final-word handshake chains straight into the next burst.
  assign accept     = frame_done && ((state == IDLE) || final_hs);
  assign drop       = frame_done && !accept;
  assign busy       = (state == SEND);
  assign nxt_ch     = out_header ? '0 : out_ch + 1'b1;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      sum_i[c] = acc_i[c] + {{(ACC_W-IN_W){data_in[(2*c+1)*IN_W-1]}}, data_in[2*c*IN_W +: IN_W]};
      sum_q[c] = acc_q[c] + {{(ACC_W-IN_W){data_in[(2*c+2)*IN_W-1]}}, data_in[(2*c+1)*IN_W +: IN_W]};
    end
  end

  always_ff @(posedge dev_clk) begin
    if (dev_rst || resync || (valid_in && frame_done)) begin
      for (int c = 0; c < N_CH; c++) begin
        acc_i[c] <= '0;
        acc_q[c] <= '0;
      end
      cnt     <= '0;
      len_lat <= len_eff;
    end else if (valid_in) begin
      for (int c = 0; c < N_CH; c++) begin
        acc_i[c] <= sum_i[c];
        acc_q[c] <= sum_q[c];
      end
      cnt <= cnt + ONE;
    end
  end

  always_ff @(posedge dev_clk) begin
    if (dev_rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      overrun   <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        snap_i[c] <= '0;
        snap_q[c] <= '0;
      end
`ifdef IQ_ACCUM_HEADER_EN
      out_header <= 1'b0;
      frame_cnt  <= '0;
`endif
    end else begin
      if (drop)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;

      if (accept) begin
        state     <= SEND;
        out_valid <= 1'b1;
        out_ch    <= '0;
        for (int c = 0; c < N_CH; c++) begin
          snap_i[c] <= sum_i[c];
          snap_q[c] <= sum_q[c];
        end
`ifdef IQ_ACCUM_HEADER_EN
        out_header <= 1'b1;
        out_last   <= 1'b0;
        out_data   <= {{(2*ACC_W-32){1'b0}}, frame_cnt};
        frame_cnt  <= frame_cnt + 32'd1;
`else
        // First word bypasses the snapshot, which only lands on this same edge.
        out_last   <= (N_CH == 1);
        out_data   <= {sum_q[0], sum_i[0]};
`endif
      end else if (hs) begin
        if (out_last) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          out_ch   <= nxt_ch;
          out_last <= (nxt_ch == CH_W'(N_CH - 1));
          out_data <= {snap_q[nxt_ch], snap_i[nxt_ch]};
`ifdef IQ_ACCUM_HEADER_EN
          out_header <= 1'b0;
`endif
        end
      end
    end
  end

endmodule
